convolution_engine_param: RTL and testbench
===========================================

// Module: convolution_engine_param
// PURPOSE
//  Parametrised successor of the fixed-size convolution processor: Z[i] = sum_j Y[j]*H[i-j].
//  Runtime sizeY and sizeH; H is held in a loadable coefficient register file, not a ROM.
//  The j-loop visits only valid j (no wasted iterations). The MAC is pipelined at one tap per cycle.
//  Reads Y from external sync memory (1-cycle latency) and writes Z to external memory.
// PARAMETERS
//  DY_W  8   width of Y samples (unsigned)
//  DH_W  8   width of H coefficients (unsigned)
//  DZ_W  16  width of dataZ output
//  MAX_Y 32  max sizeY; AY_W = $clog2(MAX_Y), SY_W = AY_W+1
//  MAX_H 32  max sizeH; AH_W = $clog2(MAX_H), SH_W = AH_W+1
//  AZ_W  derived: $clog2(MAX_Y+MAX_H-1); ACC_W = DY_W+DH_W+AH_W (internal accumulator)
// PORTS
//  clk        in   1      clock
//  rstn       in   1      synchronous active-low reset
//  start      in   1      begin convolution; sampled only in IDLE
//  sizeY      in   SY_W   number of Y samples; latched on start
//  sizeH      in   SH_W   number of H taps; latched on start
//  h_wr       in   1      coefficient write strobe; ignored while busy
//  h_addr     in   AH_W   coefficient write address
//  h_data     in   DH_W   coefficient write data
//  memY_addr  out  AY_W   Y read address; dataY is valid one cycle later
//  dataY      in   DY_W   Y read data
//  memZ_addr  out  AZ_W   Z write address
//  dataZ      out  DZ_W   Z write data
//  writeZ     out  1      Z write strobe, one cycle per output sample
//  busy       out  1      operation in progress
//  done       out  1      1-cycle pulse at end of operation
//  err        out  1      1-cycle pulse with done when the sizes are illegal
// BEHAVIOUR
//  Reset: all outputs 0; FSM in IDLE; H file cleared to 0; i, j and accumulator cleared.
//  Reset mid-operation aborts on the next edge. No further writeZ is issued.
//  FSM: IDLE -> SETUP -> RUN -> DRAIN -> WRITE -> (RUN | FIN) -> IDLE.
//  IDLE: start=1 latches sizeY/sizeH; busy=1 from the next cycle.
//  SETUP: if sizeY==0, sizeH==0, sizeY>MAX_Y or sizeH>MAX_H -> FIN with err.
//   Otherwise set i=0, nZ=sizeY+sizeH-1, and go to RUN.
//  Per output i: jmin = (i>=sizeH-1) ? i-sizeH+1 : 0; jmax = min(i, sizeY-1); accumulator cleared.
//  RUN: issue memY_addr=j for j=jmin..jmax, one per cycle. The H address is i-j.
//  Pipe stages: addr (t) -> dataY and H read (t+1) -> product register (t+2) -> accumulate (t+3).
//  DRAIN: wait until the last tap is accumulated, 3 cycles after the last address is issued.
//  WRITE: one cycle with writeZ=1, memZ_addr=i, dataZ=result(acc). Then i++.
//   If i==nZ go to FIN, else go to RUN.
//  Cycles per output = (jmax-jmin+1) + 4.
//  FIN: done=1 (and err if set) for exactly one cycle; busy=1 in FIN, 0 the next cycle.
//  start while busy: ignored. h_wr while busy: ignored, H unchanged.
//  h_wr in IDLE together with start: the write takes effect before SETUP.
//  Unsigned arithmetic. Products are DY_W+DH_W bits. ACC_W cannot overflow for legal sizes.
// CONFIGURATION
//  CONV_SATURATE_EN defined: result(acc) = (acc > 2**DZ_W-1) ? 2**DZ_W-1 : acc[DZ_W-1:0].
//  Not defined: result(acc) = acc[DZ_W-1:0] (wrap modulo 2**DZ_W).
// STRUCTURE
//  Package conv_engine_pkg: typedef enum conv_state_e {IDLE,SETUP,RUN,DRAIN,WRITE,FIN};
//   pipeline depth constant MAC_LAT=3; width-helper functions.
//  Sub-module conv_mac_pipe: product register + accumulator with clr/valid inputs and ACC_W output.
//  Top holds the FSM, the i/j counters, the H register file and the output registers.
// TESTING
//  1 H={1,2,3}, sizeH=3, Y={1,1}, sizeY=2 -> writeZ at addr 0..3 with Z={1,3,5,3}; one done pulse; err=0.
//  2 H=32x255, Y=32x255 -> Z[31] = 0xFFFF with CONV_SATURATE_EN, 0xC020 without (raw 0x1FC020).
//  3 sizeY=0 (then separately sizeH=33) -> done and err pulse together in FIN; no writeZ; busy falls next cycle.
//  4 h_wr to addr 0 while busy -> H[0] unchanged (checked by rerun); start while busy -> no restart.
//  5 rstn low during RUN -> next edge: busy=0, writeZ=0, memY_addr=0; new start then runs scenario 1 correctly.
//  6 sizeY=1, sizeH=1, Y={7}, H={9} -> a single write Z[0]=63; cycle count from start to done matches the formula.

Source files
------------

// File: rtl/conv_engine_pkg.sv
// Shared types and width helpers for the parametrised convolution engine.
// The CONV_SATURATE_EN macro is consumed by the top (output clamping), not here.
package conv_engine_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        RUN   = 3'd2,
        DRAIN = 3'd3,
        WRITE = 3'd4,
        FIN   = 3'd5
    } conv_state_e;

    // Address-to-accumulate latency of the MAC pipeline.
    localparam int MAC_LAT = 3;

    function automatic int addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int acc_w(input int dy_w, input int dh_w, input int max_h);
        return dy_w + dh_w + addr_w(max_h);
    endfunction

endpackage

// File: rtl/conv_mac_pipe.sv
// Two-stage multiply-accumulate: registered product, then accumulator.
// clr has priority over an arriving product.
module conv_mac_pipe
    import conv_engine_pkg::*;
#(
    parameter int DY_W  = 8,
    parameter int DH_W  = 8,
    parameter int ACC_W = 21
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             clr,
    input  logic             in_vld,
    input  logic [DY_W-1:0]  y,
    input  logic [DH_W-1:0]  h,
    output logic [ACC_W-1:0] acc
);

    localparam int P_W = DY_W + DH_W;

    logic [P_W-1:0]   prod_d, prod_q;
    logic             prod_vld_d, prod_vld_q;
    logic [ACC_W-1:0] acc_d, acc_q;

    // Next-state of product register and accumulator
    always_comb begin
        prod_vld_d = in_vld;
        if (in_vld) begin
            prod_d = {{DH_W{1'b0}}, y} * {{DY_W{1'b0}}, h};
        end else begin
            prod_d = prod_q;
        end
        if (clr) begin
            acc_d = {ACC_W{1'b0}};
        end else if (prod_vld_q) begin
            acc_d = acc_q + ACC_W'(prod_q);
        end else begin
            acc_d = acc_q;
        end
    end

    // Pipeline registers with synchronous reset
    always_ff @(posedge clk) begin
        if (!rstn) begin
            prod_q     <= {P_W{1'b0}};
            prod_vld_q <= 1'b0;
            acc_q      <= {ACC_W{1'b0}};
        end else begin
            prod_q     <= prod_d;
            prod_vld_q <= prod_vld_d;
            acc_q      <= acc_d;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/convolution_engine_param.sv
// Runtime-sized 1-D convolution Z[i] = sum_j Y[j]*H[i-j], one tap per cycle.
// Define CONV_SATURATE_EN to clamp outputs at 2**DZ_W-1 instead of wrapping.
module convolution_engine_param
    import conv_engine_pkg::*;
#(
    parameter  int DY_W  = 8,
    parameter  int DH_W  = 8,
    parameter  int DZ_W  = 16,
    parameter  int MAX_Y = 32,
    parameter  int MAX_H = 32,
    localparam int AY_W  = addr_w(MAX_Y),
    localparam int SY_W  = AY_W + 1,
    localparam int AH_W  = addr_w(MAX_H),
    localparam int SH_W  = AH_W + 1,
    localparam int AZ_W  = addr_w(MAX_Y + MAX_H - 1),
    localparam int ACC_W = acc_w(DY_W, DH_W, MAX_H)
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            start,
    input  logic [SY_W-1:0] sizeY,
    input  logic [SH_W-1:0] sizeH,
    input  logic            h_wr,
    input  logic [AH_W-1:0] h_addr,
    input  logic [DH_W-1:0] h_data,
    output logic [AY_W-1:0] memY_addr,
    input  logic [DY_W-1:0] dataY,
    output logic [AZ_W-1:0] memZ_addr,
    output logic [DZ_W-1:0] dataZ,
    output logic            writeZ,
    output logic            busy,
    output logic            done,
    output logic            err
);

    // One extra bit so i+1 and sizeY+sizeH-1 never wrap.
    localparam int IW = AZ_W + 1;
    localparam logic [1:0] DRAIN_LAST = 2'(MAC_LAT - 1);

    conv_state_e      state_d, state_q;
    logic [SY_W-1:0]  sy_d, sy_q;
    logic [SH_W-1:0]  sh_d, sh_q;
    logic [IW-1:0]    nz_d, nz_q;
    logic [AZ_W-1:0]  i_d, i_q;
    logic [IW-1:0]    i_next;
    logic [AY_W-1:0]  j_d, j_q;
    logic [AY_W-1:0]  jmax_d, jmax_q;
    logic [1:0]       dcnt_d, dcnt_q;
    logic             busy_d, busy_q;
    logic             done_d, done_q;
    logic             err_d, err_q;
    logic             writez_d, writez_q;
    logic [AZ_W-1:0]  memz_addr_d, memz_addr_q;
    logic [DZ_W-1:0]  dataz_d, dataz_q;
    logic             vld1_d, vld1_q;
    logic [AH_W-1:0]  hidx_d, hidx_q;
    logic [DH_W-1:0]  h_file_d [MAX_H];
    logic [DH_W-1:0]  h_file_q [MAX_H];
    logic             mac_clr;
    logic [ACC_W-1:0] acc;

    function automatic logic [AY_W-1:0] first_tap(input logic [AZ_W-1:0] i,
                                                  input logic [SH_W-1:0] sh);
        logic [IW-1:0] ie;
        logic [IW-1:0] lag;
        ie  = IW'(i);
        lag = IW'(sh) - IW'(1);
        if (ie >= lag) begin
            first_tap = AY_W'(ie - lag);
        end else begin
            first_tap = {AY_W{1'b0}};
        end
    endfunction

    function automatic logic [AY_W-1:0] last_tap(input logic [AZ_W-1:0] i,
                                                 input logic [SY_W-1:0] sy);
        logic [IW-1:0] ie;
        logic [IW-1:0] ylast;
        ie    = IW'(i);
        ylast = IW'(sy) - IW'(1);
        if (ie < ylast) begin
            last_tap = AY_W'(ie);
        end else begin
            last_tap = AY_W'(ylast);
        end
    endfunction

    function automatic logic [DZ_W-1:0] z_result(input logic [ACC_W-1:0] a);
`ifdef CONV_SATURATE_EN
        if (a > ACC_W'({DZ_W{1'b1}})) begin
            z_result = {DZ_W{1'b1}};
        end else begin
            z_result = a[DZ_W-1:0];
        end
`else
        z_result = a[DZ_W-1:0];
`endif
    endfunction

    // Sequencing FSM and output register next-state
    always_comb begin
        state_d     = state_q;
        sy_d        = sy_q;
        sh_d        = sh_q;
        nz_d        = nz_q;
        i_d         = i_q;
        j_d         = j_q;
        jmax_d      = jmax_q;
        dcnt_d      = dcnt_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        writez_d    = 1'b0;
        memz_addr_d = memz_addr_q;
        dataz_d     = dataz_q;
        i_next      = IW'(i_q) + IW'(1);
        case (state_q)
            IDLE: begin
                if (start) begin
                    sy_d    = sizeY;
                    sh_d    = sizeH;
                    busy_d  = 1'b1;
                    state_d = SETUP;
                end else begin
                    state_d = IDLE;
                end
            end
            SETUP: begin
                if ((sy_q == {SY_W{1'b0}}) || (sh_q == {SH_W{1'b0}}) ||
                    (sy_q > SY_W'(MAX_Y)) || (sh_q > SH_W'(MAX_H))) begin
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                    state_d = FIN;
                end else begin
                    i_d     = {AZ_W{1'b0}};
                    nz_d    = IW'(sy_q) + IW'(sh_q) - IW'(1);
                    j_d     = first_tap({AZ_W{1'b0}}, sh_q);
                    jmax_d  = last_tap({AZ_W{1'b0}}, sy_q);
                    state_d = RUN;
                end
            end
            RUN: begin
                if (j_q == jmax_q) begin
                    dcnt_d  = 2'd0;
                    state_d = DRAIN;
                end else begin
                    j_d = j_q + AY_W'(1);
                end
            end
            DRAIN: begin
                // acc holds the final sum during the last drain cycle.
                if (dcnt_q == DRAIN_LAST) begin
                    writez_d    = 1'b1;
                    memz_addr_d = i_q;
                    dataz_d     = z_result(acc);
                    state_d     = WRITE;
                end else begin
                    dcnt_d = dcnt_q + 2'd1;
                end
            end
            WRITE: begin
                i_d = AZ_W'(i_next);
                if (i_next == nz_q) begin
                    done_d  = 1'b1;
                    state_d = FIN;
                end else begin
                    j_d     = first_tap(AZ_W'(i_next), sh_q);
                    jmax_d  = last_tap(AZ_W'(i_next), sy_q);
                    state_d = RUN;
                end
            end
            FIN: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // Address stage: tap valid and H index travel alongside the Y read
    always_comb begin
        vld1_d = (state_q == RUN);
        hidx_d = AH_W'(IW'(i_q) - IW'(j_q));
    end

    // Coefficient file accepts writes only while idle
    always_comb begin
        h_file_d = h_file_q;
        if (h_wr && (state_q == IDLE) && (int'(h_addr) < MAX_H)) begin
            h_file_d[h_addr] = h_data;
        end else begin
            h_file_d = h_file_q;
        end
    end

    assign mac_clr = (state_q != RUN) && (state_q != DRAIN);

    conv_mac_pipe #(
        .DY_W  (DY_W),
        .DH_W  (DH_W),
        .ACC_W (ACC_W)
    ) u_mac (
        .clk    (clk),
        .rstn   (rstn),
        .clr    (mac_clr),
        .in_vld (vld1_q),
        .y      (dataY),
        .h      (h_file_q[hidx_q]),
        .acc    (acc)
    );

    // State, counters, coefficient file and output registers
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= IDLE;
            sy_q        <= {SY_W{1'b0}};
            sh_q        <= {SH_W{1'b0}};
            nz_q        <= {IW{1'b0}};
            i_q         <= {AZ_W{1'b0}};
            j_q         <= {AY_W{1'b0}};
            jmax_q      <= {AY_W{1'b0}};
            dcnt_q      <= 2'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            writez_q    <= 1'b0;
            memz_addr_q <= {AZ_W{1'b0}};
            dataz_q     <= {DZ_W{1'b0}};
            vld1_q      <= 1'b0;
            hidx_q      <= {AH_W{1'b0}};
            for (int k = 0; k < MAX_H; k++) begin
                h_file_q[k] <= {DH_W{1'b0}};
            end
        end else begin
            state_q     <= state_d;
            sy_q        <= sy_d;
            sh_q        <= sh_d;
            nz_q        <= nz_d;
            i_q         <= i_d;
            j_q         <= j_d;
            jmax_q      <= jmax_d;
            dcnt_q      <= dcnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            writez_q    <= writez_d;
            memz_addr_q <= memz_addr_d;
            dataz_q     <= dataz_d;
            vld1_q      <= vld1_d;
            hidx_q      <= hidx_d;
            h_file_q    <= h_file_d;
        end
    end

    assign memY_addr = j_q;
    assign memZ_addr = memz_addr_q;
    assign dataZ     = dataz_q;
    assign writeZ    = writez_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_convolution_engine_param.sv
// Randomised and directed bench for convolution_engine_param against a sum-of-products model.
// Honours CONV_SATURATE_EN when computing expected outputs.
module tb_convolution_engine_param;

    localparam int DY_W = 8;
    localparam int DH_W = 8;
    localparam int DZ_W = 16;
    localparam int AY_W = 5;
    localparam int SY_W = 6;
    localparam int AH_W = 5;
    localparam int SH_W = 6;
    localparam int AZ_W = 6;

    logic            clk    = 1'b0;
    logic            rstn   = 1'b0;
    logic            start  = 1'b0;
    logic [SY_W-1:0] sizeY  = '0;
    logic [SH_W-1:0] sizeH  = '0;
    logic            h_wr   = 1'b0;
    logic [AH_W-1:0] h_addr = '0;
    logic [DH_W-1:0] h_data = '0;
    logic [AY_W-1:0] memY_addr;
    logic [DY_W-1:0] dataY  = '0;
    logic [AZ_W-1:0] memZ_addr;
    logic [DZ_W-1:0] dataZ;
    logic            writeZ, busy, done, err;

    logic [7:0] ymem [32];
    int         hm   [32];
    int         zgot [64];
    int         zwr  [64];
    int         n_chk = 0;
    int         n_bad = 0;

    always #5 clk = ~clk;

    convolution_engine_param dut (
        .clk       (clk),
        .rstn      (rstn),
        .start     (start),
        .sizeY     (sizeY),
        .sizeH     (sizeH),
        .h_wr      (h_wr),
        .h_addr    (h_addr),
        .h_data    (h_data),
        .memY_addr (memY_addr),
        .dataY     (dataY),
        .memZ_addr (memZ_addr),
        .dataZ     (dataZ),
        .writeZ    (writeZ),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    // Synchronous Y memory with one cycle of read latency
    always @(posedge clk) dataY <= ymem[memY_addr];

    task automatic check_val(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    function automatic longint model_z(input int i, input int sy, input int sh);
        longint s = 0;
        for (int j = 0; j < sy; j++) begin
            if (i - j >= 0 && i - j < sh) s += longint'(ymem[j]) * longint'(hm[i - j]);
        end
`ifdef CONV_SATURATE_EN
        return (s > 65535) ? 65535 : s;
`else
        return s % 65536;
`endif
    endfunction

    function automatic int model_taps(input int i, input int sy, input int sh);
        int n = 0;
        for (int j = 0; j < sy; j++) begin
            if (i - j >= 0 && i - j < sh) n++;
        end
        return n;
    endfunction

    task automatic load_h(input int a, input int d);
        @(negedge clk);
        h_wr   = 1'b1;
        h_addr = AH_W'(a);
        h_data = DH_W'(d);
        @(negedge clk);
        h_wr   = 1'b0;
        hm[a]  = d;
    endtask

    task automatic run_case(input string tag, input int sy, input int sh,
                            input bit inj, input bit hw_start, input int hd,
                            output int cyc_out);
        int cyc = 0;
        int nwr = 0;
        int multi = 0;
        int exp_cyc;
        bit got_done = 1'b0;
        bit got_err = 1'b0;
        bit legal;
        for (int k = 0; k < 64; k++) begin
            zgot[k] = -1;
            zwr[k]  = 0;
        end
        @(negedge clk);
        start = 1'b1;
        sizeY = SY_W'(sy);
        sizeH = SH_W'(sh);
        if (hw_start) begin
            h_wr   = 1'b1;
            h_addr = 5'd0;
            h_data = DH_W'(hd);
            hm[0]  = hd;
        end
        @(negedge clk);
        start = 1'b0;
        h_wr  = 1'b0;
        cyc   = 1;
        while (!got_done && cyc < 4000) begin
            // Optional disturbance: restart request and H write while busy
            if (inj && cyc == 3) begin
                start  = 1'b1;
                sizeY  = 6'd1;
                sizeH  = 6'd1;
                h_wr   = 1'b1;
                h_addr = 5'd0;
                h_data = 8'hAA;
            end else begin
                start = 1'b0;
                h_wr  = 1'b0;
            end
            if (writeZ) begin
                nwr++;
                zwr[memZ_addr]++;
                zgot[memZ_addr] = int'(dataZ);
            end
            if (done) begin
                got_done = 1'b1;
                got_err  = err;
                check_val({tag, ".busy_at_done"}, busy, 1);
            end else begin
                @(negedge clk);
                cyc++;
            end
        end
        start = 1'b0;
        h_wr  = 1'b0;
        cyc_out = cyc;
        check_val({tag, ".done_seen"}, got_done, 1);
        legal   = (sy >= 1 && sy <= 32 && sh >= 1 && sh <= 32);
        exp_cyc = 2;
        if (legal) begin
            for (int i = 0; i < sy + sh - 1; i++) exp_cyc += model_taps(i, sy, sh) + 4;
        end
        check_val({tag, ".cycles"}, cyc, exp_cyc);
        check_val({tag, ".err"}, got_err, legal ? 0 : 1);
        check_val({tag, ".nwrites"}, nwr, legal ? sy + sh - 1 : 0);
        if (legal) begin
            for (int i = 0; i < sy + sh - 1; i++) begin
                if (zwr[i] != 1) multi++;
                check_val($sformatf("%s.z[%0d]", tag, i), zgot[i], model_z(i, sy, sh));
            end
            check_val({tag, ".write_once"}, multi, 0);
        end
        @(negedge clk);
        check_val({tag, ".busy_after"}, busy, 0);
        check_val({tag, ".done_after"}, done, 0);
    endtask

    initial begin
        int cyc;
        int nwr;
        int e1 [4] = '{1, 3, 5, 3};
        for (int k = 0; k < 32; k++) begin
            ymem[k] = 8'd0;
            hm[k]   = 0;
        end

        repeat (3) @(negedge clk);
        check_val("rst.busy", busy, 0);
        check_val("rst.done", done, 0);
        check_val("rst.err", err, 0);
        check_val("rst.writeZ", writeZ, 0);
        check_val("rst.memY_addr", memY_addr, 0);
        check_val("rst.memZ_addr", memZ_addr, 0);
        check_val("rst.dataZ", dataZ, 0);
        rstn = 1'b1;

        // Small worked example
        load_h(0, 1); load_h(1, 2); load_h(2, 3);
        ymem[0] = 8'd1; ymem[1] = 8'd1;
        run_case("s1", 2, 3, 1'b0, 1'b0, 0, cyc);
        for (int i = 0; i < 4; i++) check_val($sformatf("s1.const[%0d]", i), zgot[i], e1[i]);

        run_case("busy_inj", 2, 3, 1'b1, 1'b0, 0, cyc);
        run_case("rerun", 2, 3, 1'b0, 1'b0, 0, cyc);
        check_val("rerun.h0", zgot[0], 1);

        run_case("sizeY0", 0, 3, 1'b0, 1'b0, 0, cyc);
        run_case("sizeH33", 3, 33, 1'b0, 1'b0, 0, cyc);

        // Full-size, all-ones-byte data
        for (int k = 0; k < 32; k++) begin
            ymem[k] = 8'hFF;
            load_h(k, 255);
        end
        run_case("full", 32, 32, 1'b0, 1'b0, 0, cyc);
`ifdef CONV_SATURATE_EN
        check_val("full.z31", zgot[31], 65535);
`else
        check_val("full.z31", zgot[31], 49184);
`endif

        // Reset while the datapath is running
        load_h(0, 1); load_h(1, 2); load_h(2, 3);
        ymem[0] = 8'd1; ymem[1] = 8'd1;
        @(negedge clk);
        start = 1'b1; sizeY = 6'd2; sizeH = 6'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        check_val("midrst.busy_before", busy, 1);
        rstn = 1'b0;
        @(negedge clk);
        check_val("midrst.busy", busy, 0);
        check_val("midrst.writeZ", writeZ, 0);
        check_val("midrst.memY_addr", memY_addr, 0);
        check_val("midrst.done", done, 0);
        rstn = 1'b1;
        for (int k = 0; k < 32; k++) hm[k] = 0;
        nwr = 0;
        repeat (12) begin
            @(negedge clk);
            if (writeZ) nwr++;
        end
        check_val("midrst.no_writes", nwr, 0);
        run_case("h_cleared", 2, 3, 1'b0, 1'b0, 0, cyc);
        load_h(0, 1); load_h(1, 2); load_h(2, 3);
        run_case("s1_again", 2, 3, 1'b0, 1'b0, 0, cyc);

        // Single tap, coefficient written in the same cycle as start
        ymem[0] = 8'd7;
        run_case("single", 1, 1, 1'b0, 1'b1, 9, cyc);
        check_val("single.z0", zgot[0], 63);
        check_val("single.cyc", cyc, 7);

        for (int r = 0; r < 6; r++) begin
            for (int k = 0; k < 32; k++) begin
                ymem[k] = 8'($urandom);
                load_h(k, int'($urandom_range(0, 255)));
            end
            run_case($sformatf("rnd%0d", r), int'($urandom_range(1, 32)),
                     int'($urandom_range(1, 32)), 1'b0, 1'b0, 0, cyc);
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
